// File: rtl/btn_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// btn_cmd_ctrl_if
// Purpose : valid/ready command handshake between the button command
//           controller (master) and its consumer (slave).
// Signals : o_cmd_valid  master->slave  command available
//           i_cmd_ready  slave->master  consumer accepts when high with valid
//           o_cmd_btn    master->slave  index of the originating button
//           o_cmd_kind   master->slave  00 short, 01 long, 10 repeat
// ---------------------------------------------------------------------------
interface btn_cmd_ctrl_if;
  logic       o_cmd_valid;
  logic       i_cmd_ready;
  logic [1:0] o_cmd_btn;
  logic [1:0] o_cmd_kind;

  modport master (
    output o_cmd_valid,
    output o_cmd_btn,
    output o_cmd_kind,
    input  i_cmd_ready
  );

  modport slave (
    input  o_cmd_valid,
    input  o_cmd_btn,
    input  o_cmd_kind,
    output i_cmd_ready
  );
endinterface

// File: rtl/btn_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// btn_cmd_ctrl
// Purpose : turns debounced press/release events from four buttons into
//           short / long / auto-repeat commands. One button is tracked at a
//           time; commands go out through a one-entry valid/ready register.
// Ports   : clk          system clock, rising edge
//           rst          asynchronous active-high reset
//           i_state[3:0] debounced level per button (1 = pressed)
//           i_ondn[3:0]  one-cycle press pulse per button
//           i_onup[3:0]  one-cycle release pulse per button
//           cmd          command handshake (master side)
//           o_busy       a button is being tracked
//           o_overflow   one-cycle pulse when a command was dropped
// ---------------------------------------------------------------------------
module btn_cmd_ctrl #(
  parameter int         LONG_CYCLES   = 100_000_000,
  parameter int         REPEAT_CYCLES = 20_000_000,
  parameter logic [3:0] REPEAT_MASK   = 4'b0110
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            i_state,
  input  logic [3:0]            i_ondn,
  input  logic [3:0]            i_onup,
  btn_cmd_ctrl_if.master        cmd,
  output logic                  o_busy,
  output logic                  o_overflow
);

  localparam logic [26:0] LONG_LAST   = 27'(LONG_CYCLES - 1);
  localparam logic [26:0] REPEAT_LAST = 27'(REPEAT_CYCLES - 1);

  localparam logic [1:0] KIND_SHORT  = 2'b00;
  localparam logic [1:0] KIND_LONG   = 2'b01;
  localparam logic [1:0] KIND_REPEAT = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_act;
  logic [26:0] r_cnt;
  logic        r_cmd_valid;
  logic [1:0]  r_cmd_btn;
  logic [1:0]  r_cmd_kind;
  logic        r_overflow;
  logic        r_busy;

  logic [1:0]  w_first_idx;
  logic        w_release;
  logic        w_gen;
  logic [1:0]  w_gen_kind;

  // Lowest-numbered button wins when several press on the same edge.
  always_comb begin
    w_first_idx = 2'd0;
    if (i_ondn[0])      w_first_idx = 2'd0;
    else if (i_ondn[1]) w_first_idx = 2'd1;
    else if (i_ondn[2]) w_first_idx = 2'd2;
    else if (i_ondn[3]) w_first_idx = 2'd3;
  end

  // A dropped level counts as a release even if the onup pulse was missed.
  assign w_release = i_onup[r_act] | ~i_state[r_act];

  // Command decision for this edge; release beats long on the same edge.
  always_comb begin
    w_gen      = 1'b0;
    w_gen_kind = KIND_SHORT;
    case (r_state)
      PRESSED: begin
        if (w_release) begin
          w_gen      = 1'b1;
          w_gen_kind = KIND_SHORT;
        end else if (r_cnt == LONG_LAST) begin
          w_gen      = 1'b1;
          w_gen_kind = KIND_LONG;
        end
      end
      HELD: begin
        if (!w_release && REPEAT_MASK[r_act] && (r_cnt == REPEAT_LAST)) begin
          w_gen      = 1'b1;
          w_gen_kind = KIND_REPEAT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_act       <= 2'd0;
      r_cnt       <= 27'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_btn   <= 2'd0;
      r_cmd_kind  <= 2'd0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_overflow <= 1'b0;

      case (r_state)
        IDLE: begin
          if (|i_ondn) begin
            r_act   <= w_first_idx;
            r_cnt   <= 27'd0;
            r_state <= PRESSED;
            r_busy  <= 1'b1;
          end
        end
        PRESSED: begin
          if (w_release) begin
            r_cnt   <= 27'd0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == LONG_LAST) begin
            r_cnt   <= 27'd0;
            r_state <= HELD;
          end else begin
            r_cnt <= r_cnt + 27'd1;
          end
        end
        HELD: begin
          if (w_release) begin
            r_cnt   <= 27'd0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (REPEAT_MASK[r_act]) begin
            if (r_cnt == REPEAT_LAST) r_cnt <= 27'd0;
            else                      r_cnt <= r_cnt + 27'd1;
          end else begin
            // Non-repeating button: park the counter until release.
            r_cnt <= 27'd0;
          end
        end
        default: begin
          r_cnt   <= 27'd0;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // One-entry output register. Acceptance and a new load on the same
      // edge leave valid high with no bubble.
      if (w_gen) begin
        if (!r_cmd_valid || cmd.i_cmd_ready) begin
          r_cmd_valid <= 1'b1;
          r_cmd_btn   <= r_act;
          r_cmd_kind  <= w_gen_kind;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_cmd_valid && cmd.i_cmd_ready) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

  assign cmd.o_cmd_valid = r_cmd_valid;
  assign cmd.o_cmd_btn   = r_cmd_btn;
  assign cmd.o_cmd_kind  = r_cmd_kind;
  assign o_busy          = r_busy;
  assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btn_cmd_ctrl
// Purpose : self-checking bench for btn_cmd_ctrl with LONG_CYCLES=16 and
//           REPEAT_CYCLES=4. Each row/step applies inputs before a rising
//           edge and checks the registered outputs 1 ns after that edge.
// ---------------------------------------------------------------------------
module tb_btn_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] st;
  logic [3:0] dn;
  logic [3:0] up;
  logic       busy;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  btn_cmd_ctrl_if cmd_if ();

  btn_cmd_ctrl #(
    .LONG_CYCLES  (16),
    .REPEAT_CYCLES(4),
    .REPEAT_MASK  (4'b0110)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_state   (st),
    .i_ondn    (dn),
    .i_onup    (up),
    .cmd       (cmd_if.master),
    .o_busy    (busy),
    .o_overflow(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] st;
    logic [3:0] dn;
    logic [3:0] up;
    logic       rdy;
    logic       ev;
    logic [1:0] eb;
    logic [1:0] ek;
    logic       ebusy;
    logic       eovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [3:0] s, logic [3:0] d, logic [3:0] u,
                             logic r, logic ev, logic [1:0] eb,
                             logic [1:0] ek, logic ebusy, logic eovf);
    vec_t x;
    x.st = s; x.dn = d; x.up = u; x.rdy = r;
    x.ev = ev; x.eb = eb; x.ek = ek; x.ebusy = ebusy; x.eovf = eovf;
    return x;
  endfunction

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_outs(string tag, logic ev, logic [1:0] eb, logic [1:0] ek,
                          logic ebusy, logic eovf);
    $display("%s: valid=%0b btn=%0d kind=%0d busy=%0b ovf=%0b",
             tag, cmd_if.o_cmd_valid, cmd_if.o_cmd_btn, cmd_if.o_cmd_kind, busy, ovf);
    chk({tag, " valid"}, int'(cmd_if.o_cmd_valid), int'(ev));
    if (ev) begin
      chk({tag, " btn"},  int'(cmd_if.o_cmd_btn),  int'(eb));
      chk({tag, " kind"}, int'(cmd_if.o_cmd_kind), int'(ek));
    end
    chk({tag, " busy"}, int'(busy), int'(ebusy));
    chk({tag, " ovf"},  int'(ovf),  int'(eovf));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- table ----------------
    // short press button 2, release 5 edges later
    vecs.push_back(v(4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(4'b0100, 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b0100, 1, 1, 2, 0, 0, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    // level drop without onup acts as release
    vecs.push_back(v(4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    // buttons 1 and 3 on the same edge: 1 tracked, 3 ignored
    vecs.push_back(v(4'b1010, 4'b1010, 4'b0000, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(4'b1010, 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(4'b0010, 4'b0000, 4'b1000, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(4'b1010, 4'b1000, 4'b0000, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(4'b1000, 4'b0000, 4'b0010, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(4'b1000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b1000, 1, 0, 0, 0, 0, 0));
    // ready low: second short dropped with overflow pulse
    vecs.push_back(v(4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b0001, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(4'b1000, 4'b1000, 4'b0000, 0, 1, 0, 0, 1, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b1000, 0, 1, 0, 0, 0, 1));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    // accept and load on the same edge: no bubble
    vecs.push_back(v(4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b0010, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(4'b0100, 4'b0100, 4'b0000, 0, 1, 1, 0, 1, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b0100, 1, 1, 2, 0, 0, 0));
    vecs.push_back(v(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));

    // ---------------- reset ----------------
    rst = 1'b1; st = '0; dn = '0; up = '0; cmd_if.i_cmd_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk_outs("reset", 0, 0, 0, 0, 0);

    // ---------------- table loop ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      st = vecs[i].st; dn = vecs[i].dn; up = vecs[i].up;
      cmd_if.i_cmd_ready = vecs[i].rdy;
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eb, vecs[i].ek,
               vecs[i].ebusy, vecs[i].eovf);
    end
    st = '0; dn = '0; up = '0; cmd_if.i_cmd_ready = 1'b1;
    step();

    // ---------------- long press, button 0 (no repeat) ----------------
    st = 4'b0001; dn = 4'b0001;
    step();
    chk_outs("long0 E0", 0, 0, 0, 1, 0);
    dn = '0;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk_outs($sformatf("long0 E0+%0d", k), (k == 16), 0, 2'b01, 1, 0);
    end
    st = '0; up = 4'b0001;
    step();
    chk_outs("long0 release", 0, 0, 0, 0, 0);
    up = '0;
    step();
    chk_outs("long0 idle", 0, 0, 0, 0, 0);

    // ---------------- long + repeat, button 1 ----------------
    st = 4'b0010; dn = 4'b0010;
    step();
    chk_outs("rep1 E0", 0, 0, 0, 1, 0);
    dn = '0;
    for (int k = 1; k <= 29; k++) begin
      logic       ev;
      logic [1:0] ek;
      ev = (k == 16) || (k == 20) || (k == 24) || (k == 28);
      ek = (k == 16) ? 2'b01 : 2'b10;
      step();
      chk_outs($sformatf("rep1 E0+%0d", k), ev, 2'd1, ek, 1, 0);
    end
    st = '0; up = 4'b0010;
    step();
    chk_outs("rep1 release", 0, 0, 0, 0, 0);
    up = '0;
    step();

    // ---------------- reset during a held press ----------------
    cmd_if.i_cmd_ready = 1'b0;
    st = 4'b0100; dn = 4'b0100;
    step();
    dn = '0; st = '0; up = 4'b0100;
    step();
    chk_outs("rst pending", 1, 2, 0, 0, 0);
    up = '0;
    st = 4'b0010; dn = 4'b0010;
    step();
    dn = '0;
    for (int k = 1; k <= 8; k++) step();
    chk_outs("rst E0+8", 1, 2, 0, 1, 0);
    #1 rst = 1'b1;
    #1;
    chk_outs("rst async", 0, 0, 0, 0, 0);
    chk("rst async btn",  int'(cmd_if.o_cmd_btn),  0);
    chk("rst async kind", int'(cmd_if.o_cmd_kind), 0);
    step(); step();
    rst = 1'b0;
    cmd_if.i_cmd_ready = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk_outs($sformatf("post-rst hold %0d", k), 0, 0, 0, 0, 0);
    end
    dn = 4'b0010;
    step();
    chk_outs("post-rst new press", 0, 0, 0, 1, 0);
    dn = '0; st = '0; up = 4'b0010;
    step();
    chk_outs("post-rst short", 1, 1, 0, 0, 0);
    up = '0;
    step();
    chk_outs("post-rst idle", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_cmd_ctrl.md
BTN_CMD_CTRL -- requirements
Module: btn_cmd_ctrl

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 100_000_000, hold time in clk cycles for a long-press (1 s at 100 MHz); legal range 2..2^27-1.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 20_000_000, auto-repeat period in clk cycles after a long-press; legal range 2..2^27-1.
REQ-003 SHALL have parameter REPEAT_MASK, default 4'b0110, per-button auto-repeat enable (bit i = button i).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_state  input  4  debounced level per button (1 = pressed).
REQ-007 i_ondn  input  4  one-cycle press pulse per button from debouncers.
REQ-008 i_onup  input  4  one-cycle release pulse per button from debouncers.
REQ-009 o_cmd_valid  output  1  command available.
REQ-010 i_cmd_ready  input  1  consumer accepts command when high with o_cmd_valid.
REQ-011 o_cmd_btn  output  2  index of button that generated the command.
REQ-012 o_cmd_kind  output  2  00 short, 01 long, 10 repeat, 11 unused.
REQ-013 o_busy  output  1  high while a button is being tracked (FSM not IDLE).
REQ-014 o_overflow  output  1  one-cycle pulse when a generated command is dropped.

Function
REQ-015 FSM states SHALL be IDLE, PRESSED, HELD; one active-button register act[1:0]; one 27-bit counter cnt.
REQ-016 IDLE: on any i_ondn bit set, SHALL capture lowest set index into act, clear cnt, go PRESSED; otherwise stay.
REQ-017 While not IDLE, i_ondn/i_onup/i_state of non-active buttons SHALL be ignored; they generate no commands.
REQ-018 PRESSED: i_onup[act] sampled -> SHALL generate short command, go IDLE; takes priority over long on same edge.
REQ-019 PRESSED: else cnt==LONG_CYCLES-1 -> SHALL generate long command, clear cnt, go HELD; else cnt increments.
REQ-020 HELD: i_onup[act] -> SHALL go IDLE with no command.
REQ-021 HELD, REPEAT_MASK[act]=1: cnt==REPEAT_CYCLES-1 -> SHALL generate repeat command, clear cnt; else cnt increments.
REQ-022 HELD, REPEAT_MASK[act]=0: cnt SHALL hold at 0; no further commands until release.
REQ-023 i_state[act]==0 while not IDLE without i_onup SHALL be treated as release (same as REQ-018/020).
REQ-024 Output is a one-entry register: generated command SHALL appear on o_cmd_* one cycle after the deciding edge.
REQ-025 o_cmd_valid SHALL stay high, with o_cmd_btn/o_cmd_kind stable, until a cycle with o_cmd_valid & i_cmd_ready.
REQ-026 New command on the same edge as acceptance SHALL load directly; o_cmd_valid stays high, no bubble.
REQ-027 New command while o_cmd_valid=1 and i_cmd_ready=0 SHALL be dropped, held entry unchanged, o_overflow pulsed next cycle.
REQ-028 cnt SHALL never wrap; comparisons use full 27-bit width.
REQ-029 o_busy SHALL be registered state (state != IDLE).

Reset
REQ-030 rst high SHALL immediately force IDLE, act=0, cnt=0, o_cmd_valid=0, o_cmd_btn=0, o_cmd_kind=0, o_overflow=0, o_busy=0.
REQ-031 Reset mid-press SHALL discard tracking; a button still held after rst release SHALL produce nothing until its next i_ondn.
REQ-032 Pending unaccepted command SHALL be lost on reset.

Verification (LONG_CYCLES=16, REPEAT_CYCLES=4, i_cmd_ready=1 unless stated)
REQ-033 i_ondn[2] edge E0, i_onup[2] at E0+5 -> one cycle o_cmd_valid=1, btn=2, kind=00, after E0+5; o_busy low after E0+5.
REQ-034 i_ondn[0] at E0, held 40 cycles (mask bit 0 = 0) -> exactly one long (btn=0, kind=01) after E0+16; nothing else; release -> nothing.
REQ-035 i_ondn[1] at E0, held to E0+30 -> long after E0+16, repeats (kind=10) after E0+20, +24, +28; release -> none.
REQ-036 i_ondn=4'b1010 same edge -> act=1 tracked; button 3 press/release ignored; short from button 1 only.
REQ-037 i_cmd_ready=0, two short presses -> first held stable, second dropped, o_overflow one pulse; ready=1 -> first accepted, valid drops.
REQ-038 rst asserted at E0+8 of held button 1 -> all outputs 0 asynchronously; after rst release, no long/repeat until new i_ondn.
